// File: rtl/servo_pwm_decoder.sv
// Servo PWM receive decoder: measures high time and frame period, decodes to a 5-step position.
// Optional build macro SERVO_DEC_FILTER_EN: position only commits after two matching good frames.
module servo_pwm_decoder #(
   parameter int unsigned WIDTH_MIN  = 20_000,
   parameter int unsigned WIDTH_MAX  = 105_000,
   parameter int unsigned PERIOD_MIN = 900_000,
   parameter int unsigned PERIOD_MAX = 1_100_000,
   parameter int unsigned POS_TH0    = 34_375,
   parameter int unsigned POS_TH1    = 53_125,
   parameter int unsigned POS_TH2    = 71_875,
   parameter int unsigned POS_TH3    = 90_625
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        PWM_IN,
   output logic [20:0] ANCHO,
   output logic [2:0]  POSI,
   output logic        VALIDO,
   output logic        ERR
);

   localparam int CNT_W = 21;

   localparam logic [CNT_W-1:0] W_MIN  = CNT_W'(WIDTH_MIN);
   localparam logic [CNT_W-1:0] W_MAX  = CNT_W'(WIDTH_MAX);
   localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(PERIOD_MIN);
   localparam logic [CNT_W-1:0] P_MAX  = CNT_W'(PERIOD_MAX);
   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(PERIOD_MAX + 1);
   localparam logic [CNT_W-1:0] TH0    = CNT_W'(POS_TH0);
   localparam logic [CNT_W-1:0] TH1    = CNT_W'(POS_TH1);
   localparam logic [CNT_W-1:0] TH2    = CNT_W'(POS_TH2);
   localparam logic [CNT_W-1:0] TH3    = CNT_W'(POS_TH3);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, ALTO, BAJO} state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + ONE;
   endfunction

   function automatic logic [2:0] decode_pos(input logic [CNT_W-1:0] w);
      if (w < TH0)      return 3'd0;
      else if (w < TH1) return 3'd1;
      else if (w < TH2) return 3'd2;
      else if (w < TH3) return 3'd3;
      else              return 3'd4;
   endfunction

   function automatic logic frame_ok(input logic [CNT_W-1:0] w, input logic [CNT_W-1:0] p);
      return (w >= W_MIN) && (w <= W_MAX) && (p >= P_MIN) && (p <= P_MAX);
   endfunction

   logic             sync_p0, sync_p1, s_d;
   logic             rise, fall;
   state_t           state;
   logic [CNT_W-1:0] wid_cnt, per_cnt, width_lat;
   logic             frame_good;
   logic [2:0]       pos_new;
`ifdef SERVO_DEC_FILTER_EN
   logic             cand_vld;
   logic [2:0]       cand_pos;
`endif

   // Stage p0/p1: two-flop synchronizer; s_d holds history. All ones at reset so a
   // line already high is not mistaken for a rising edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
         s_d     <= 1'b1;
      end else begin
         sync_p0 <= PWM_IN;
         sync_p1 <= sync_p0;
         s_d     <= sync_p1;
      end
   end

   assign rise       = sync_p1 & ~s_d;
   assign fall       = ~sync_p1 & s_d;
   assign frame_good = frame_ok(width_lat, per_cnt);
   assign pos_new    = decode_pos(width_lat);

   // Stage p2: frame FSM; counters and latched width are always loaded before use.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         ANCHO  <= '0;
         POSI   <= '0;
         VALIDO <= 1'b0;
         ERR    <= 1'b0;
`ifdef SERVO_DEC_FILTER_EN
         cand_vld <= 1'b0;
         cand_pos <= '0;
`endif
      end else begin
         VALIDO <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  state   <= ALTO;
                  wid_cnt <= ONE;
                  per_cnt <= ONE;
               end
            end
            ALTO: begin
               if (per_cnt == TO_CNT) begin
                  ERR   <= 1'b1;
                  state <= IDLE;
`ifdef SERVO_DEC_FILTER_EN
                  cand_vld <= 1'b0;
`endif
               end else begin
                  wid_cnt <= sat_inc(wid_cnt);
                  per_cnt <= sat_inc(per_cnt);
                  if (fall) begin
                     width_lat <= wid_cnt;
                     state     <= BAJO;
                  end
               end
            end
            BAJO: begin
               if (per_cnt == TO_CNT) begin
                  ERR   <= 1'b1;
                  state <= IDLE;
`ifdef SERVO_DEC_FILTER_EN
                  cand_vld <= 1'b0;
`endif
               end else if (rise) begin
                  // The closing edge of this frame also opens the next one.
                  state   <= ALTO;
                  wid_cnt <= ONE;
                  per_cnt <= ONE;
                  if (frame_good) begin
                     VALIDO <= 1'b1;
                     ANCHO  <= width_lat;
                     ERR    <= 1'b0;
`ifdef SERVO_DEC_FILTER_EN
                     if (cand_vld && (cand_pos == pos_new))
                        POSI <= pos_new;
                     cand_vld <= 1'b1;
                     cand_pos <= pos_new;
`else
                     POSI <= pos_new;
`endif
                  end else begin
                     ERR <= 1'b1;
`ifdef SERVO_DEC_FILTER_EN
                     cand_vld <= 1'b0;
`endif
                  end
               end else begin
                  per_cnt <= sat_inc(per_cnt);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder with timing scaled by 1/625 so full frames stay short.
module tb_servo_pwm_decoder;

   localparam int WMIN = 32;
   localparam int WMAX = 168;
   localparam int PMIN = 1440;
   localparam int PMAX = 1760;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        PWM_IN = 1'b0;
   logic [20:0] ANCHO;
   logic [2:0]  POSI;
   logic        VALIDO;
   logic        ERR;

   servo_pwm_decoder #(
      .WIDTH_MIN(WMIN), .WIDTH_MAX(WMAX), .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX),
      .POS_TH0(55), .POS_TH1(85), .POS_TH2(115), .POS_TH3(145)
   ) dut (
      .CLK(CLK), .RST(RST), .PWM_IN(PWM_IN),
      .ANCHO(ANCHO), .POSI(POSI), .VALIDO(VALIDO), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   int    errors = 0;
   int    checks = 0;
   int    vld_seen = 0;
   int    exp_vld_total = 0;
   int    exp_anch = 0;
   int    exp_posi = 0;
   bit    exp_err = 1'b0;
   bit    open = 1'b0;
   int    prev_h = 0;
   int    prev_l = 0;
   bit    cand_vld = 1'b0;
   int    cand_pos = 0;
   string phase = "reset";

   always @(posedge CLK) if (VALIDO === 1'b1) vld_seen <= vld_seen + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, expv);
      end
   endtask

   function automatic int model_pos(input int w);
      int th[4];
      int idx;
      th  = '{55, 85, 115, 145};
      idx = 0;
      foreach (th[i]) if (w >= th[i]) idx++;
      return idx;
   endfunction

   function automatic bit model_good(input int w, input int p);
      return (w >= WMIN) && (w <= WMAX) && (p >= PMIN) && (p <= PMAX);
   endfunction

   task automatic model_reset();
      exp_anch = 0; exp_posi = 0; exp_err = 1'b0; open = 1'b0; cand_vld = 1'b0; cand_pos = 0;
   endtask

   // Rising edge at the current negedge: closes the open frame (if any) and checks the verdict.
   task automatic open_rise();
      bit vld;
      int idx;
      vld = 1'b0;
      if (open) begin
         if (prev_h + prev_l > PMAX) begin
            exp_err = 1'b1; cand_vld = 1'b0;
         end else if (model_good(prev_h, prev_h + prev_l)) begin
            vld = 1'b1; exp_anch = prev_h; exp_err = 1'b0; exp_vld_total++;
            idx = model_pos(prev_h);
`ifdef SERVO_DEC_FILTER_EN
            if (cand_vld && cand_pos == idx) exp_posi = idx;
            cand_vld = 1'b1; cand_pos = idx;
`else
            exp_posi = idx;
`endif
         end else begin
            exp_err = 1'b1; cand_vld = 1'b0;
         end
      end
      open = 1'b1;
      PWM_IN = 1'b1;
      repeat (3) @(negedge CLK);
      chk("valido", 32'(VALIDO), 32'(vld));
      chk("ancho", 32'(ANCHO), 32'(exp_anch));
      chk("posi", 32'(POSI), 32'(exp_posi));
      chk("err", 32'(ERR), 32'(exp_err));
      @(negedge CLK);
      chk("valido_end", 32'(VALIDO), 0);
   endtask

   task automatic frame(input int h, input int l);
      open_rise();
      repeat (h - 4) @(negedge CLK);
      PWM_IN = 1'b0;
      repeat (l) @(negedge CLK);
      prev_h = h;
      prev_l = l;
   endtask

   task automatic stuck_low(input int h);
      int n;
      open_rise();
      n = 4;
      while (n < h) begin @(negedge CLK); n++; end
      PWM_IN = 1'b0;
      while (n < PMAX + 3) begin @(negedge CLK); n++; end
      chk("err_before_to", 32'(ERR), 32'(exp_err));
      @(negedge CLK);
      chk("err_at_to", 32'(ERR), 1);
      exp_err = 1'b1; open = 1'b0; cand_vld = 1'b0;
      repeat (40) @(negedge CLK);
   endtask

   task automatic check_zero_outputs();
      chk("rst_ancho", 32'(ANCHO), 0);
      chk("rst_posi", 32'(POSI), 0);
      chk("rst_valido", 32'(VALIDO), 0);
      chk("rst_err", 32'(ERR), 0);
   endtask

   initial begin
      int h, per, cat;
      int w2[6];
      w2 = '{40, 70, 130, 160, 54, 55};

      repeat (2) @(negedge CLK);
      check_zero_outputs();
      RST = 1'b0;
      model_reset();
      repeat (10) @(negedge CLK);

      phase = "nominal";
      repeat (3) frame(100, 1501);

      phase = "decode";
      foreach (w2[i]) frame(w2[i], 1600 - w2[i]);

      phase = "bad_width";
      frame(130, 1470);
      frame(176, 1424);
      frame(100, 1500);
      frame(100, 1500);

      phase = "timeout";
      stuck_low(100);
      frame(100, 1500);
      frame(100, 1500);

      phase = "mid_reset";
      open_rise();
      repeat (20) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check_zero_outputs();
      RST = 1'b0;
      model_reset();
      repeat (20) @(negedge CLK);
      PWM_IN = 1'b0;
      repeat (1500) @(negedge CLK);
      frame(100, 1500);
      frame(100, 1500);

      phase = "filter_seq";
      frame(100, 1500);
      frame(100, 1500);
      frame(160, 1440);
      frame(100, 1500);
      frame(100, 1500);

      phase = "random";
      for (int k = 0; k < 10; k++) begin
         cat = int'($urandom_range(0, 4));
         h   = int'($urandom_range(WMIN, WMAX));
         per = int'($urandom_range(PMIN, PMAX));
         if (cat == 2) begin
            h = ($urandom_range(0, 1) == 0) ? int'($urandom_range(4, WMIN - 1))
                                            : int'($urandom_range(WMAX + 1, WMAX + 60));
         end else if (cat == 3) begin
            per = int'($urandom_range(WMAX + 100, PMIN - 1));
         end else if (cat == 4) begin
            per = int'($urandom_range(PMAX + 2, PMAX + 60));
         end
         frame(h, per - h);
      end

      phase = "final";
      open_rise();
      repeat (20) @(negedge CLK);
      PWM_IN = 1'b0;
      repeat (20) @(negedge CLK);
      chk("valido_count", 32'(vld_seen), 32'(exp_vld_total));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
